// File: rtl/comando_pkg.sv
// Shared types and helpers for the push-button front end.
package comando_pkg;

    // Per-channel debounce/repeat FSM states
    typedef enum logic [1:0] {
        SOLTO       = 2'b00,
        CONF_PRESS  = 2'b01,
        PRESSIONADO = 2'b10,
        CONF_SOLT   = 2'b11
    } estado_t;

    // Normalised button level after polarity correction
    localparam logic PRESSED  = 1'b1;
    localparam logic RELEASED = 1'b0;

    // Bits needed to hold values 0..n (never less than 1)
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/comando_botoes_if.sv
// Button inputs and increment/decrement outputs of the front end.
interface comando_botoes_if;
    logic btn_up;
    logic btn_down;
    logic acrescer;
    logic decrecer;
    logic up_held;
    logic down_held;

    modport master (
        output btn_up, btn_down,
        input  acrescer, decrecer, up_held, down_held
    );

    modport slave (
        input  btn_up, btn_down,
        output acrescer, decrecer, up_held, down_held
    );
endinterface

// File: rtl/canal_botao.sv
// One button channel: 2-flop synchroniser, debounce FSM, auto-repeat
// counter and a registered one-cycle pulse.
module canal_botao
    import comando_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic held
);
    // Repeat intervals below 2 would place pulses back to back
    localparam int RD = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
    localparam int RP = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam int RW = cnt_w(max_i(RD, RP));

    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_FIM = RW'(RD - 1);
    localparam logic [RW-1:0] PER_FIM = RW'(RP - 1);
    localparam logic RAW_SOLTO = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [1:0]    sync_q;
    logic          s;
    estado_t       est, est_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] rpt, rpt_n;
    logic          rep, rep_n;   // 1 once the first repeat has fired
    logic          pulse_n;

    assign s    = (sync_q[1] == RAW_SOLTO) ? RELEASED : PRESSED;
    assign held = (est == PRESSIONADO) || (est == CONF_SOLT);

    // Two-flop synchroniser; reset loads the released level
    always_ff @(posedge clk) begin
        if (rst) sync_q <= {2{RAW_SOLTO}};
        else     sync_q <= {sync_q[0], btn};
    end

    // State, counters and pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            est   <= SOLTO;
            cnt   <= '0;
            rpt   <= '0;
            rep   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            est   <= est_n;
            cnt   <= cnt_n;
            rpt   <= rpt_n;
            rep   <= rep_n;
            pulse <= pulse_n;
        end
    end

    // Next-state: debounce in both directions, repeat only while pressed
    always_comb begin
        est_n   = est;
        cnt_n   = cnt;
        rpt_n   = rpt;
        rep_n   = rep;
        pulse_n = 1'b0;
        case (est)
            SOLTO: begin
                if (s) begin
                    est_n = CONF_PRESS;
                    cnt_n = '0;
                end
            end
            CONF_PRESS: begin
                if (!s) begin
                    est_n = SOLTO;
                end else if (cnt == CNT_FIM) begin
                    est_n   = PRESSIONADO;
                    pulse_n = 1'b1;
                    rpt_n   = '0;
                    rep_n   = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (!s) begin
                    est_n = CONF_SOLT;
                    cnt_n = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rpt == (rep ? PER_FIM : DLY_FIM)) begin
                        pulse_n = 1'b1;
                        rpt_n   = '0;
                        rep_n   = 1'b1;
                    end else begin
                        rpt_n = rpt + 1'b1;
                    end
                end
            end
            CONF_SOLT: begin
                // repeat count is frozen here and resumes on a bounce back
                if (s) begin
                    est_n = PRESSIONADO;
                end else if (cnt == CNT_FIM) begin
                    est_n = SOLTO;
                    rpt_n = '0;
                    rep_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: est_n = SOLTO;
        endcase
    end

endmodule

// File: rtl/comando_botoes.sv
// Button front end for the up/down counter: two independent channels,
// outputs forwarded straight to acrescer/decrecer.
module comando_botoes
    import comando_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    comando_botoes_if.slave  bus
);

    canal_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_up (
        .clk(clk), .rst(rst), .btn(bus.btn_up),
        .pulse(bus.acrescer), .held(bus.up_held)
    );

    canal_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(REPEAT_EN),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
        .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_down (
        .clk(clk), .rst(rst), .btn(bus.btn_down),
        .pulse(bus.decrecer), .held(bus.down_held)
    );

endmodule

// File: doc/comando_botoes.md
Name: comando_botoes

Overview:
- Front-end stage feeding the 8-bit up/down counter (load value 0x6A).
- Takes two raw, asynchronous push-button levels (up, down) and, per channel, synchronises, debounces and edge-detects them.
- Outputs one-cycle increment/decrement pulses, with optional auto-repeat while a button is held.
- Outputs connect directly to the counter's acrescer/decrecer inputs.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press or a release; must be ≥1.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives a single pulse per press.
- REPEAT_DELAY, 50000: cycles from the initial press pulse to the first repeat pulse; must be ≥1.
- REPEAT_PERIOD, 10000: cycles between subsequent repeat pulses; must be ≥1.
- BTN_ACTIVE_LOW, 1: 1 means a raw level of 0 is "pressed"; 0 means a raw level of 1 is "pressed".

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_up  in  1  raw up-button level, asynchronous.
- btn_down  in  1  raw down-button level, asynchronous.
- acrescer  out  1  one-cycle increment pulse.
- decrecer  out  1  one-cycle decrement pulse.
- up_held  out  1  high while the up channel is in debounced-pressed state.
- down_held  out  1  high while the down channel is in debounced-pressed state.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst is high at a rising edge:
  - synchroniser flops load the released level;
  - FSMs go to SOLTO; counters clear;
  - acrescer, decrecer, up_held, down_held are all 0 after that edge.
- Reset mid-operation aborts any press or repeat. A button still held after reset deasserts is treated as a new press and produces a fresh debounced pulse.
- Synchroniser: each raw input passes through 2 flops, then is normalised to s (1 = pressed) using BTN_ACTIVE_LOW.
- Per-channel FSM and debounce counter:
  - cnt width = clog2(DEBOUNCE_CYCLES+1).
  - Repeat counter width = clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- FSM states:
  - SOLTO: if s=1, go to CONF_PRESS with cnt=0.
  - CONF_PRESS: if s=0, go to SOLTO (glitch rejected, no pulse). Else, if cnt==DEBOUNCE_CYCLES-1, go to PRESSIONADO and register pulse=1. Else cnt++.
  - PRESSIONADO: held=1.
    - If s=0, go to CONF_SOLT with cnt=0.
    - Otherwise, when REPEAT_EN=1, the repeat counter runs. It emits a pulse when it reaches REPEAT_DELAY after the initial pulse, then every REPEAT_PERIOD cycles thereafter, reloading each time.
  - CONF_SOLT: held stays 1; the repeat counter freezes; no pulses.
    - If s=1, return to PRESSIONADO and resume the frozen repeat count.
    - Else, if cnt==DEBOUNCE_CYCLES-1, go to SOLTO with held=0 and the repeat counter cleared. Else cnt++.
- Pulse timing: pulses are registered, exactly 1 cycle wide, never back-to-back from the same channel.
- Latency: with raw input first sampled pressed at edge 0 and then stable, the pulse is high in the cycle following edge DEBOUNCE_CYCLES+2. held rises on the same edge.
- Independence: the two channels are fully independent. Simultaneous pulses on both outputs are forwarded unchanged; the counter treats 11 as hold. No arbitration here.
- No pulse is generated on release.

Decomposition:
- Shared package comando_pkg holds:
  - the state enum: SOLTO, CONF_PRESS, PRESSIONADO, CONF_SOLT (2-bit encoding);
  - the PRESSED/RELEASED level constants;
  - a helper for counter widths.
- Sub-module canal_botao, instantiated twice (up, down), holds the synchroniser, FSM, debounce counter, repeat counter, pulse register and held output. The top level contains only the instances and port mapping.

Test Plan:
Unless noted, benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, BTN_ACTIVE_LOW=1.
1. Clean press: btn_up driven 0 before edge 0 and held 100 cycles -> acrescer high only in the cycle after edge 6; up_held=1 from edge 6. Repeat pulses follow 20 cycles later, then every 8 cycles. decrecer stays 0.
2. Glitch rejection: btn_down low for 3 cycles, then high -> no decrecer pulse; down_held stays 0; FSM returns to SOLTO.
3. Bounce on release: in PRESSIONADO, btn_up high 2 cycles, low 1 cycle, then high -> no extra pulse. up_held falls 4 stable cycles after the final rise is synchronised.
4. REPEAT_EN=0: hold btn_up 200 cycles -> exactly one acrescer pulse.
5. Simultaneous: both buttons pressed on the same edge -> acrescer and decrecer are both high in the same single cycle; both held signals are 1.
6. Reset mid-hold: assert rst for 1 cycle while up is in PRESSIONADO with the button still low -> all outputs 0 after the edge. A new acrescer pulse occurs 6 edges after rst deasserts, and the repeat schedule restarts.
